// File: rtl/poly_mul_seq_if.sv
// -----------------------------------------------------------------------------
// poly_mul_seq_if
// Control bundle between the polynomial-multiplier sequencer and its
// surroundings (coefficient banks, twiddle ROMs, butterfly datapath, host).
//
// Signals:
//   start     run request (host -> sequencer)
//   done      one-cycle end-of-run pulse
//   busy      run in progress, including the done cycle
//   phase     0 IDLE, 1 NTT, 2 PWM, 3 INTT, 4 SCALE, 5 DONE
//   stage     butterfly stage within NTT/INTT, otherwise 0
//   rd_en     bank read strobe, rd_addr bank read row
//   wr_en     bank write strobe, wr_addr bank write row
//   rom_addr  twiddle ROM address, rom_inv selects the inverse ROM set
//   host_req  host asks for bank ownership, host_gnt host owns the banks
//
// Modports: master = sequencer, slave = everything around it.
// -----------------------------------------------------------------------------
interface poly_mul_seq_if #(
  parameter int ADDR_W = 7,
  parameter int ROM_AW = 9
);
  logic              start;
  logic              done;
  logic              busy;
  logic [2:0]        phase;
  logic [3:0]        stage;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_inv;
  logic              host_req;
  logic              host_gnt;

  modport master (
    input  start, host_req,
    output done, busy, phase, stage, rd_en, rd_addr, wr_en, wr_addr,
           rom_addr, rom_inv, host_gnt
  );

  modport slave (
    output start, host_req,
    input  done, busy, phase, stage, rd_en, rd_addr, wr_en, wr_addr,
           rom_addr, rom_inv, host_gnt
  );
endinterface

// File: rtl/poly_mul_seq.sv
// -----------------------------------------------------------------------------
// poly_mul_seq
// Top-level sequencer of the 1024-point polynomial multiplier. A run walks
// forward NTT (STAGES passes), pointwise multiply (1 pass), inverse NTT
// (STAGES passes) and N^-1 scaling (1 pass), then pulses done for one cycle.
// Every pass issues 2^ADDR_W row reads and then drains for PIPE_LAT cycles;
// writes are the reads delayed by PIPE_LAT. The host may own the banks only
// while the sequencer is idle.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (aborts a run, flushes the write line)
//   bus  poly_mul_seq_if.master: start/done/busy/phase/stage, bank read and
//        write strobes and rows, twiddle ROM address/select, host_req/host_gnt
// -----------------------------------------------------------------------------
module poly_mul_seq #(
  parameter int ADDR_W   = 7,
  parameter int STAGES   = 10,
  parameter int PIPE_LAT = 4,
  parameter int ROM_AW   = 9
) (
  input  logic          clk,
  input  logic          rst,
  poly_mul_seq_if.master bus
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_NTT   = 3'd1,
    PH_PWM   = 3'd2,
    PH_INTT  = 3'd3,
    PH_SCALE = 3'd4,
    PH_DONE  = 3'd5
  } phase_e;

  localparam int                DCW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROW    = '1;
  localparam logic [DCW-1:0]    LAST_DRAIN  = DCW'(PIPE_LAT - 1);
  localparam logic [3:0]        LAST_STAGE  = 4'(STAGES - 1);
  localparam logic [3:0]        LOG_ROWS    = 4'(ADDR_W);
  // Late stages use the second half of the ROM; the scaling constant follows it.
  localparam logic [ROM_AW-1:0] ROM_HI_BASE = ROM_AW'(1 << ADDR_W);
  localparam logic [ROM_AW-1:0] ROM_SCALE   = ROM_AW'(2 << ADDR_W);

  phase_e            phase_q, phase_d;
  logic [3:0]        stage_q, stage_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;
  logic [DCW-1:0]    dcnt_q,  dcnt_d;
  logic              drain_q, drain_d;
  logic              gnt_q,   gnt_d;
  logic              start_ok;
  logic              issue;
  logic [ROM_AW-1:0] rom_addr;

  // ---------------------------------------------------------------------------
  // Sequencer state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values of the others, regardless of statement order.
    if (rst) begin
      phase_q <= PH_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      drain_q <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      drain_q <= drain_d;
      gnt_q   <= gnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    phase_d  = phase_q;
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    drain_d  = drain_q;
    start_ok = 1'b0;

    case (phase_q)
      PH_IDLE: begin
        // A granted host blocks start; start otherwise wins over a new request.
        if (bus.start && !gnt_q) begin
          start_ok = 1'b1;
          phase_d  = PH_NTT;
          stage_d  = '0;
          cnt_d    = '0;
          dcnt_d   = '0;
          drain_d  = 1'b0;
        end
      end
      PH_DONE: phase_d = PH_IDLE;
      default: begin
        if (!drain_q) begin
          // Row counter wraps back to 0 on the last issue.
          if (cnt_q == LAST_ROW) begin
            drain_d = 1'b1;
            dcnt_d  = '0;
          end
          cnt_d = cnt_q + 1'b1;
        end else if (dcnt_q == LAST_DRAIN) begin
          drain_d = 1'b0;
          cnt_d   = '0;
          stage_d = '0;
          case (phase_q)
            PH_NTT:  if (stage_q == LAST_STAGE) phase_d = PH_PWM;
                     else stage_d = stage_q + 4'd1;
            PH_PWM:  phase_d = PH_INTT;
            PH_INTT: if (stage_q == LAST_STAGE) phase_d = PH_SCALE;
                     else stage_d = stage_q + 4'd1;
            default: phase_d = PH_DONE;
          endcase
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    endcase

    // Grant only while idle and not being overtaken by a start this cycle.
    gnt_d = bus.host_req && (phase_q == PH_IDLE) && !start_ok;
  end

  assign issue = (phase_q inside {PH_NTT, PH_PWM, PH_INTT, PH_SCALE}) && !drain_q;

  // ---------------------------------------------------------------------------
  // Twiddle addressing: early stages step through the first half of the ROM
  // coarsely, the last stages index the second half at finer granularity.
  // ---------------------------------------------------------------------------
  always_comb begin
    rom_addr = '0;
    if (issue) begin
      case (phase_q)
        PH_NTT, PH_INTT: begin
          if (stage_q < LOG_ROWS)
            rom_addr = ROM_AW'(cnt_q) >> (LOG_ROWS - stage_q);
          else
            rom_addr = ROM_HI_BASE + (ROM_AW'(cnt_q) >> (LAST_STAGE - stage_q));
        end
        PH_SCALE: rom_addr = ROM_SCALE;
        default:  rom_addr = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write side: read strobe and row delayed by the datapath latency
  // ---------------------------------------------------------------------------
  logic              wen_pipe   [PIPE_LAT];
  logic [ADDR_W-1:0] waddr_pipe [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this delay line is reset on purpose: an aborted run must not
      // leave in-flight writes that land after reset.
      for (int i = 0; i < PIPE_LAT; i++) begin
        wen_pipe[i]   <= 1'b0;
        waddr_pipe[i] <= '0;
      end
    end else begin
      wen_pipe[0]   <= issue;
      waddr_pipe[0] <= issue ? cnt_q : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wen_pipe[i]   <= wen_pipe[i-1];
        waddr_pipe[i] <= waddr_pipe[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registered state)
  // ---------------------------------------------------------------------------
  assign bus.done     = (phase_q == PH_DONE);
  assign bus.busy     = (phase_q != PH_IDLE);
  assign bus.phase    = phase_q;
  assign bus.stage    = stage_q;
  assign bus.rd_en    = issue;
  assign bus.rd_addr  = issue ? cnt_q : '0;
  assign bus.wr_en    = wen_pipe[PIPE_LAT-1];
  assign bus.wr_addr  = waddr_pipe[PIPE_LAT-1];
  assign bus.rom_addr = rom_addr;
  assign bus.rom_inv  = (phase_q == PH_INTT) || (phase_q == PH_SCALE);
  assign bus.host_gnt = gnt_q;

endmodule

// File: tb/tb_poly_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_poly_mul_seq
// Scoreboarded bench for poly_mul_seq. Stimulus pushes the expected end-of-run
// record when a start is accepted; a monitor on the falling edge pops it at
// every done pulse and also checks write alignment and twiddle addresses
// against hand-computed vectors.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_poly_mul_seq;

  localparam int ADDR_W   = 7;
  localparam int STAGES   = 10;
  localparam int PIPE_LAT = 4;
  localparam int ROM_AW   = 9;
  localparam int RUN_CYC  = 2905;  // 22 * (128 + 4) + 1
  localparam int WRITES   = 2816;  // 22 * 128
  localparam int N_TW     = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  poly_mul_seq_if #(.ADDR_W(ADDR_W), .ROM_AW(ROM_AW)) bus ();

  poly_mul_seq #(
    .ADDR_W  (ADDR_W),
    .STAGES  (STAGES),
    .PIPE_LAT(PIPE_LAT),
    .ROM_AW  (ROM_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.done, bus.busy, bus.phase, bus.stage, bus.rd_en, bus.rd_addr,
                bus.wr_en, bus.wr_addr, bus.rom_addr, bus.rom_inv, bus.host_gnt});
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard entries and hand-computed twiddle vectors
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int done_cyc;
    int busy_n;
    int wr_n;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  typedef struct packed {
    int ph;
    int st;
    int cnt;
    int rom;
    int inv;
  } tw_t;

  tw_t tw_tab [N_TW];

  initial begin
    tw_tab[0] = '{ph: 1, st: 6, cnt: 127, rom: 63,  inv: 0};
    tw_tab[1] = '{ph: 1, st: 9, cnt: 127, rom: 255, inv: 0};
    tw_tab[2] = '{ph: 1, st: 7, cnt: 5,   rom: 129, inv: 0};
    tw_tab[3] = '{ph: 1, st: 3, cnt: 100, rom: 6,   inv: 0};
    tw_tab[4] = '{ph: 2, st: 0, cnt: 64,  rom: 0,   inv: 0};
    tw_tab[5] = '{ph: 3, st: 0, cnt: 127, rom: 0,   inv: 1};
    tw_tab[6] = '{ph: 3, st: 7, cnt: 5,   rom: 129, inv: 1};
    tw_tab[7] = '{ph: 4, st: 0, cnt: 0,   rom: 256, inv: 1};
    tw_tab[8] = '{ph: 4, st: 0, cnt: 127, rom: 256, inv: 1};
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic              hist_en   [PIPE_LAT];
  logic [ADDR_W-1:0] hist_addr [PIPE_LAT];
  logic              prev_busy;
  logic [2:0]        prev_phase;
  logic [31:0]       trace;
  int busy_cnt, wr_cnt, stage_bad, gnt_bad, inv_bad;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        hist_en[i]   = 1'b0;
        hist_addr[i] = '0;
      end
      prev_busy  = 1'b0;
      prev_phase = 3'd0;
    end else begin
      // Writes must replay the reads seen PIPE_LAT samples ago.
      if (bus.wr_en || hist_en[PIPE_LAT-1])
        check("wr_align", {bus.wr_en, bus.wr_addr}, {hist_en[PIPE_LAT-1], hist_addr[PIPE_LAT-1]});
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        hist_en[i]   = hist_en[i-1];
        hist_addr[i] = hist_addr[i-1];
      end
      hist_en[0]   = bus.rd_en;
      hist_addr[0] = bus.rd_addr;

      if (bus.busy && !prev_busy) begin
        busy_cnt = 0; wr_cnt = 0; stage_bad = 0; gnt_bad = 0; inv_bad = 0; trace = '0;
      end
      if (bus.busy)  busy_cnt++;
      if (bus.wr_en) wr_cnt++;
      if (bus.busy && bus.phase != prev_phase) trace = {trace[27:0], 1'b0, bus.phase};
      if ((bus.phase inside {3'd0, 3'd2, 3'd4, 3'd5}) && bus.stage != 4'd0) stage_bad++;
      if (bus.busy && bus.host_gnt) gnt_bad++;
      if (bus.rom_inv != (bus.phase == 3'd3 || bus.phase == 3'd4)) inv_bad++;

      if (bus.rd_en) begin
        if (bus.phase == 3'd1 && bus.stage == 4'd0)
          check("rom_ntt_s0", bus.rom_addr, 0);
        for (int i = 0; i < N_TW; i++) begin
          if (int'(bus.phase) == tw_tab[i].ph && int'(bus.stage) == tw_tab[i].st &&
              int'(bus.rd_addr) == tw_tab[i].cnt)
            check($sformatf("rom ph%0d st%0d cnt%0d", tw_tab[i].ph, tw_tab[i].st, tw_tab[i].cnt),
                  {bus.rom_inv, bus.rom_addr}, 64'(tw_tab[i].inv * 512 + tw_tab[i].rom));
        end
      end

      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_unexpected: done pulse at cycle %0d, none expected", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle",     cyc,       e.done_cyc);
          check("busy_cycles",    busy_cnt,  e.busy_n);
          check("write_count",    wr_cnt,    e.wr_n);
          check("phase_trace",    trace,     32'h0001_2345);
          check("stage_zero",     stage_bad, 0);
          check("gnt_while_busy", gnt_bad,   0);
          check("rom_inv",        inv_bad,   0);
        end
      end

      prev_busy  = bus.busy;
      prev_phase = bus.phase;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic start_run(input logic req);
    @(posedge clk); #1 bus.start = 1'b1; bus.host_req = req;
    @(posedge clk); #1 bus.start = 1'b0;
    // Start was sampled at the edge just passed; done shows in the 2905th cycle.
    exp_q.push_back('{done_cyc: cyc + RUN_CYC - 1, busy_n: RUN_CYC, wr_n: WRITES});
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (bus.done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (bus.done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  initial begin
    int k;
    bus.start    = 1'b0;
    bus.host_req = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", outs(), 0);

    // Run 1 with a stray start in the middle.
    start_run(1'b0);
    @(negedge clk);
    check("first_issue", {bus.busy, bus.phase, bus.rd_en, bus.rd_addr}, {1'b1, 3'd1, 1'b1, 7'd0});
    repeat (498) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(RUN_CYC);
    @(negedge clk);
    check("idle_after_done", {bus.busy, bus.phase, bus.done}, 0);

    // Host grant in idle blocks start.
    @(posedge clk); #1 bus.host_req = 1'b1;
    @(negedge clk); check("gnt_not_yet", bus.host_gnt, 0);
    @(negedge clk); check("gnt_rise", bus.host_gnt, 1);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_ignored_granted", {bus.busy, bus.phase, bus.rd_en, bus.host_gnt}, 64'h1);
    @(posedge clk); #1 bus.host_req = 1'b0;
    @(negedge clk); check("gnt_hold", bus.host_gnt, 1);
    @(negedge clk); check("gnt_fall", bus.host_gnt, 0);

    // Start and host_req together: start wins, grant waits for idle.
    start_run(1'b1);
    @(negedge clk);
    check("start_beats_req", {bus.busy, bus.host_gnt}, 2'b10);
    wait_done(RUN_CYC + 10);
    check("gnt_in_done", bus.host_gnt, 0);
    @(negedge clk); check("gnt_idle_first", {bus.phase, bus.host_gnt}, 0);
    @(negedge clk); check("gnt_after_idle", bus.host_gnt, 1);
    @(posedge clk); #1 bus.host_req = 1'b0;
    repeat (2) @(negedge clk);

    // Abort in INTT stage 3, then a clean run.
    start_run(1'b0);
    k = 0;
    while (!(bus.phase == 3'd3 && bus.stage == 4'd3) && k < RUN_CYC) begin
      @(negedge clk);
      k++;
    end
    check("reached_intt3", {bus.phase, bus.stage}, {3'd3, 4'd3});
    @(posedge clk); #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", outs(), 0);
    repeat (PIPE_LAT + 4) @(negedge clk);
    check("abort_idle", {bus.busy, bus.wr_en, bus.done, bus.phase}, 0);

    start_run(1'b0);
    wait_done(RUN_CYC + 10);
    repeat (PIPE_LAT + 2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
